// File: rtl/iram_pkg.sv
// Shared types and constants for the instruction-RAM programming controller.
package iram_pkg;

  typedef enum logic [1:0] {IRAM_IDLE, IRAM_LEN, IRAM_DATA, IRAM_DONE} iram_state_e;

  localparam int unsigned IRAM_LEN_BYTES = 4;
  localparam int unsigned IRAM_WORD_W    = 32;
  localparam int unsigned IRAM_BCNT_W    = $clog2(IRAM_LEN_BYTES);

endpackage

// File: rtl/iram_bank.sv
// Single-port synchronous RAM bank; read data register holds when not reading.
module iram_bank #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array is not reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/iram_prog_controller.sv
// Instruction RAM responder: 1-cycle fetch reads with halfword straddle support,
// reprogrammable from a UART byte stream (length word followed by data words).
module iram_prog_controller
  import iram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          imem_en,
  input  logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_dout,
  input  logic          memcon_prog_ena,
  input  logic          uart_valid,
  input  logic [7:0]    uart_dout,
  output logic          state_load_prog,
  output logic          prog_done,
  output logic          prog_err
);

  localparam int unsigned WIDX_W     = $clog2(DEPTH_WORDS);
  localparam int unsigned BANK_AW    = WIDX_W - 1;
  localparam int unsigned BANK_DEPTH = DEPTH_WORDS / 2;
  localparam int unsigned WC_W       = WIDX_W + 1;

  iram_state_e            state_q, state_d;
  logic [IRAM_BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [23:0]            asm_q, asm_d;
  logic [31:0]            len_q, len_d;
  logic [WC_W-1:0]        wc_q, wc_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic                   ena_q;
  logic                   load_q;
  logic                   we_c;
  logic [31:0]            word_c;

  // Fetch-side index decode; upper address bits alias modulo the RAM depth.
  logic [WIDX_W-1:0]  w;
  logic [BANK_AW-1:0] rd_even_addr, rd_odd_addr;
  logic               rd_en;
  logic               unused_addr_bits;

  assign w                = imem_addr[WIDX_W+1:2];
  assign rd_odd_addr      = w[WIDX_W-1:1];
  assign rd_even_addr     = w[WIDX_W-1:1] + BANK_AW'(w[0]);
  assign rd_en            = imem_en & ~load_q;
  assign unused_addr_bits = ^{imem_addr[AW-1:WIDX_W+2], imem_addr[0]};

  // Byte assembler: newest byte enters at the top so byte0 ends in [7:0].
  assign word_c = {uart_dout, asm_q};

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    len_d   = len_q;
    wc_d    = wc_q;
    err_d   = err_q;
    done_d  = 1'b0;
    we_c    = 1'b0;
    unique case (state_q)
      IRAM_IDLE: begin
        if (memcon_prog_ena && !ena_q) begin
          err_d   = 1'b0;
          bcnt_d  = '0;
          wc_d    = '0;
          state_d = IRAM_LEN;
        end
      end
      IRAM_LEN: begin
        if (!memcon_prog_ena) begin
          state_d = IRAM_IDLE;
        end else if (uart_valid) begin
          asm_d  = word_c[31:8];
          bcnt_d = bcnt_q + IRAM_BCNT_W'(1);
          if (bcnt_q == IRAM_BCNT_W'(IRAM_LEN_BYTES - 1)) begin
            len_d = word_c;
            if (word_c == 32'd0 || word_c > 32'(DEPTH_WORDS)) begin
              err_d   = 1'b1;
              state_d = IRAM_DONE;
            end else begin
              state_d = IRAM_DATA;
            end
          end
        end
      end
      IRAM_DATA: begin
        if (!memcon_prog_ena) begin
          state_d = IRAM_IDLE;
        end else if (uart_valid) begin
          asm_d  = word_c[31:8];
          bcnt_d = bcnt_q + IRAM_BCNT_W'(1);
          if (bcnt_q == IRAM_BCNT_W'(IRAM_LEN_BYTES - 1)) begin
            we_c = 1'b1;
            wc_d = wc_q + WC_W'(1);
            if (32'(wc_q) + 32'd1 == len_q) state_d = IRAM_DONE;
          end
        end
      end
      IRAM_DONE: begin
        done_d  = ~err_q;
        state_d = IRAM_IDLE;
      end
      default: state_d = IRAM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IRAM_IDLE;
      bcnt_q  <= '0;
      asm_q   <= '0;
      len_q   <= '0;
      wc_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ena_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      len_q   <= len_d;
      wc_q    <= wc_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ena_q   <= memcon_prog_ena;
      load_q  <= (state_d != IRAM_IDLE);
    end
  end

  // Banks share one port between loader writes and fetch reads.
  logic [31:0]        even_rd, odd_rd;
  logic [BANK_AW-1:0] even_addr, odd_addr;
  logic               even_we, odd_we;

  assign even_we   = we_c & ~wc_q[0];
  assign odd_we    = we_c &  wc_q[0];
  assign even_addr = load_q ? wc_q[WIDX_W-1:1] : rd_even_addr;
  assign odd_addr  = load_q ? wc_q[WIDX_W-1:1] : rd_odd_addr;

  iram_bank #(.DEPTH(BANK_DEPTH), .ADDR_W(BANK_AW), .DATA_W(IRAM_WORD_W)) u_even (
    .clk(clk), .rst(rst), .en(rd_en | even_we), .we(even_we),
    .addr(even_addr), .wdata(word_c), .rdata(even_rd)
  );

  iram_bank #(.DEPTH(BANK_DEPTH), .ADDR_W(BANK_AW), .DATA_W(IRAM_WORD_W)) u_odd (
    .clk(clk), .rst(rst), .en(rd_en | odd_we), .we(odd_we),
    .addr(odd_addr), .wdata(word_c), .rdata(odd_rd)
  );

  // Output mux selects are captured alongside the bank reads.
  logic half_q, odd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q <= 1'b0;
      odd_q  <= 1'b0;
    end else if (rd_en) begin
      half_q <= imem_addr[1];
      odd_q  <= w[0];
    end
  end

  logic [31:0] lo_word, hi_word;

  assign lo_word   = odd_q ? odd_rd : even_rd;
  assign hi_word   = odd_q ? even_rd : odd_rd;
  assign imem_dout = load_q ? 32'd0 : (half_q ? {hi_word[15:0], lo_word[31:16]} : lo_word);

  assign state_load_prog = load_q;
  assign prog_done       = done_q;
  assign prog_err        = err_q;

endmodule

// File: tb/tb_iram_prog_controller.sv
// Directed bench for iram_prog_controller: loads, straddled reads, errors, aborts, reset.
module tb_iram_prog_controller;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        memcon_prog_ena;
  logic        uart_valid;
  logic [7:0]  uart_dout;
  logic        state_load_prog;
  logic        prog_done;
  logic        prog_err;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int d0;

  iram_prog_controller #(.DEPTH_WORDS(DEPTH), .AW(32)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .memcon_prog_ena(memcon_prog_ena), .uart_valid(uart_valid), .uart_dout(uart_dout),
    .state_load_prog(state_load_prog), .prog_done(prog_done), .prog_err(prog_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (prog_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return {16'(i * 7 + 1), 16'(i) ^ 16'hC3A5};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_valid = 1'b1;
    uart_dout  = b;
    tick();
    uart_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] wd);
    for (int k = 0; k < 4; k++) send_byte(wd[8*k +: 8]);
  endtask

  task automatic start_load();
    memcon_prog_ena = 1'b1;
    tick();
  endtask

  task automatic finish_load();
    repeat (3) tick();
    memcon_prog_ena = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [31:0] a);
    imem_en   = 1'b1;
    imem_addr = a;
    tick();
    imem_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_en = 1'b0; imem_addr = '0;
    memcon_prog_ena = 1'b0; uart_valid = 1'b0; uart_dout = '0;
    #2;
    check("rst_dout", imem_dout, 32'h0);
    check("rst_load", 32'(state_load_prog), 32'h0);
    check("rst_done", 32'(prog_done), 32'h0);
    check("rst_err", 32'(prog_err), 32'h0);
    #10 rst = 1'b0;
    tick();

    // Full-depth load (N == DEPTH is legal).
    d0 = done_cnt;
    start_load();
    check("full_busy", 32'(state_load_prog), 32'h1);
    send_word(32'(DEPTH));
    for (int i = 0; i < int'(DEPTH); i++) send_word(pat(i));
    finish_load();
    check("full_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("full_err", 32'(prog_err), 32'h0);
    check("full_idle", 32'(state_load_prog), 32'h0);
    rd(32'd20);               check("rd_w5", imem_dout, pat(5));
    rd(32'd22);               check("strad_odd", imem_dout, {pat(6)[15:0], pat(5)[31:16]});
    rd(32'd26);               check("strad_even", imem_dout, {pat(7)[15:0], pat(6)[31:16]});
    rd(32'(4*(DEPTH-1) + 2)); check("strad_wrap", imem_dout, {pat(0)[15:0], pat(DEPTH-1)[31:16]});

    // Oversized length: error, no pulse, RAM untouched.
    d0 = done_cnt;
    start_load();
    send_word(32'(DEPTH + 1));
    finish_load();
    check("big_err", 32'(prog_err), 32'h1);
    check("big_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("big_idle", 32'(state_load_prog), 32'h0);
    rd(32'd28);               check("big_ram7", imem_dout, pat(7));
    rd(32'(4*(DEPTH-1)));     check("big_ramlast", imem_dout, pat(DEPTH-1));

    // Zero length is also an error.
    d0 = done_cnt;
    start_load();
    send_word(32'd0);
    finish_load();
    check("zero_err", 32'(prog_err), 32'h1);
    check("zero_done_cnt", 32'(done_cnt - d0), 32'd0);

    // Three-word program; a read issued at load start returns 0.
    d0 = done_cnt;
    imem_en = 1'b1; imem_addr = 32'd4;
    start_load();
    imem_en = 1'b0;
    check("load_rd_zero", imem_dout, 32'h0);
    check("err_cleared", 32'(prog_err), 32'h0);
    send_word(32'd3);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    send_word(32'h8000_0537);
    finish_load();
    check("p3_done_cnt", 32'(done_cnt - d0), 32'd1);
    rd(32'h0);                check("p3_w0", imem_dout, 32'h0000_0013);
    rd(32'h2);                check("p3_strad01", imem_dout, 32'h0093_0000);
    rd(32'h4);                check("p3_w1", imem_dout, 32'h0010_0093);
    rd(32'hA);                check("p3_strad23", imem_dout, {pat(3)[15:0], 16'h8000});
    rd(32'h1000_0004);        check("p3_alias", imem_dout, 32'h0010_0093);
    rd(32'(4*(DEPTH-1) + 2)); check("p3_wrap", imem_dout, {16'h0013, pat(DEPTH-1)[31:16]});

    // Hold while imem_en is low, even if the address moves.
    rd(32'h8);
    imem_addr = 32'h0;
    repeat (3) tick();
    check("hold", imem_dout, 32'h8000_0537);

    // Abort mid-LEN: back to idle, no pulse.
    d0 = done_cnt;
    start_load();
    send_byte(8'h02);
    send_byte(8'h00);
    memcon_prog_ena = 1'b0;
    tick();
    check("abort_idle", 32'(state_load_prog), 32'h0);
    repeat (2) tick();
    check("abort_done_cnt", 32'(done_cnt - d0), 32'd0);

    // Reset mid-DATA after word 0 and two bytes of word 1.
    start_load();
    send_word(32'd2);
    send_word(32'hAABB_CCDD);
    send_byte(8'h11);
    send_byte(8'h22);
    check("pre_rst_busy", 32'(state_load_prog), 32'h1);
    rst = 1'b1; memcon_prog_ena = 1'b0;
    #1;
    check("rst_async_load", 32'(state_load_prog), 32'h0);
    #6 rst = 1'b0;
    tick();
    rd(32'h0);                check("rst_w0_kept", imem_dout, 32'hAABB_CCDD);
    rd(32'h4);                check("rst_w1_unch", imem_dout, 32'h0010_0093);
    rd(32'h8);                check("rst_w2_unch", imem_dout, 32'h8000_0537);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
